// File: rtl/mask_write_controller.sv
// Packs per-pixel mask bits into 32-bit words (LSB first) and owns the mask memory write port.
// Optional clear engine is built when MASK_CLEAR_EN is defined.
//
// state      | meaning
// IDLE       | write port idle; waits for startClear (if built) or newFrame
// CLEAR      | writes the latched fill word to every address, one per cycle
// CAPTURE    | packs valid pixels; writes each completed word
module mask_write_controller #(
   parameter int NR_OF_WORDS = 9600
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        startClear_i,
   input  logic [31:0] clearValue_i,
   input  logic        newFrame_i,
   input  logic        pixelValid_i,
   input  logic        pixelMask_i,
   output logic [13:0] memAddress_o,
   output logic        memWriteEnable_o,
   output logic [31:0] memDataOut_o,
   output logic        busy_o,
   output logic        frameDone_o,
   output logic        clearDone_o
);

   localparam logic [13:0] LAST_ADDR  = 14'(NR_OF_WORDS - 1);
   localparam logic [1:0]  ST_IDLE    = 2'd0;
   localparam logic [1:0]  ST_CAPTURE = 2'd1;
`ifdef MASK_CLEAR_EN
   localparam logic [1:0]  ST_CLEAR   = 2'd2;
`endif

   logic [1:0]  state_q, state_d;
   logic [13:0] word_addr_q, word_addr_d;
   logic [4:0]  bit_idx_q, bit_idx_d;
   logic [31:0] pack_q, pack_d;
   logic [13:0] mem_address_q, mem_address_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_data_q, mem_data_d;
   logic        busy_q, busy_d;
   logic        frame_done_q, frame_done_d;
   logic        clear_done_d;
   logic        accept_pixel;

`ifdef MASK_CLEAR_EN
   logic [31:0] clear_value_q, clear_value_d;
   logic        clear_done_q;
`else
   logic        unused_clear;
   assign unused_clear = ^{startClear_i, clearValue_i};
`endif

   always_comb begin
      state_d       = state_q;
      word_addr_d   = word_addr_q;
      bit_idx_d     = bit_idx_q;
      pack_d        = pack_q;
      mem_address_d = mem_address_q;
      mem_data_d    = mem_data_q;
      mem_we_d      = 1'b0;
      frame_done_d  = 1'b0;
      clear_done_d  = 1'b0;
      accept_pixel  = 1'b0;
`ifdef MASK_CLEAR_EN
      clear_value_d = clear_value_q;
`endif

      case (state_q)
         ST_IDLE: begin
`ifdef MASK_CLEAR_EN
            if (startClear_i) begin
               state_d       = ST_CLEAR;
               clear_value_d = clearValue_i;
               word_addr_d   = '0;
            end else
`endif
            if (newFrame_i) begin
               state_d      = ST_CAPTURE;
               word_addr_d  = '0;
               bit_idx_d    = '0;
               accept_pixel = pixelValid_i;
            end
         end
         ST_CAPTURE: begin
            // a restart drops the partial word; a coincident pixel becomes bit 0 of word 0
            if (newFrame_i) begin
               word_addr_d = '0;
               bit_idx_d   = '0;
            end
            accept_pixel = pixelValid_i;
         end
`ifdef MASK_CLEAR_EN
         ST_CLEAR: begin
            mem_we_d      = 1'b1;
            mem_address_d = word_addr_q;
            mem_data_d    = clear_value_q;
            if (word_addr_q == LAST_ADDR) begin
               clear_done_d = 1'b1;
               state_d      = ST_IDLE;
            end else begin
               word_addr_d = word_addr_q + 14'd1;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      if (accept_pixel) begin
         pack_d[bit_idx_d] = pixelMask_i;
         if (bit_idx_d == 5'd31) begin
            mem_we_d      = 1'b1;
            mem_address_d = word_addr_d;
            mem_data_d    = pack_d;
            bit_idx_d     = '0;
            if (word_addr_d == LAST_ADDR) begin
               frame_done_d = 1'b1;
               state_d      = ST_IDLE;
            end else begin
               word_addr_d = word_addr_d + 14'd1;
            end
         end else begin
            bit_idx_d = bit_idx_d + 5'd1;
         end
      end

      // busy stays high through the final write cycle even though the FSM is already idle
      busy_d = (state_d != ST_IDLE) | frame_done_d | clear_done_d;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q       <= ST_IDLE;
         word_addr_q   <= '0;
         bit_idx_q     <= '0;
         pack_q        <= '0;
         mem_address_q <= '0;
         mem_we_q      <= 1'b0;
         mem_data_q    <= '0;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
`ifdef MASK_CLEAR_EN
         clear_value_q <= '0;
         clear_done_q  <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         word_addr_q   <= word_addr_d;
         bit_idx_q     <= bit_idx_d;
         pack_q        <= pack_d;
         mem_address_q <= mem_address_d;
         mem_we_q      <= mem_we_d;
         mem_data_q    <= mem_data_d;
         busy_q        <= busy_d;
         frame_done_q  <= frame_done_d;
`ifdef MASK_CLEAR_EN
         clear_value_q <= clear_value_d;
         clear_done_q  <= clear_done_d;
`endif
      end
   end

   assign memAddress_o     = mem_address_q;
   assign memWriteEnable_o = mem_we_q;
   assign memDataOut_o     = mem_data_q;
   assign busy_o           = busy_q;
   assign frameDone_o      = frame_done_q;
`ifdef MASK_CLEAR_EN
   assign clearDone_o      = clear_done_q;
`else
   assign clearDone_o      = 1'b0;
`endif

endmodule

// File: tb/tb_mask_write_controller.sv
// Bench for mask_write_controller: directed scenarios plus random traffic, every cycle
// compared against a pixel-list / write-schedule reference model.
module tb_mask_write_controller;

   localparam int NW = 80;
`ifdef MASK_CLEAR_EN
   localparam bit CLR_EN = 1'b1;
`else
   localparam bit CLR_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset;
   logic        startClear;
   logic [31:0] clearValue;
   logic        newFrame;
   logic        pixelValid;
   logic        pixelMask;
   logic [13:0] memAddress;
   logic        memWriteEnable;
   logic [31:0] memDataOut;
   logic        busy;
   logic        frameDone;
   logic        clearDone;

   always #5 clock = ~clock;

   mask_write_controller #(.NR_OF_WORDS(NW)) dut (
      .clock_i          (clock),
      .reset_i          (reset),
      .startClear_i     (startClear),
      .clearValue_i     (clearValue),
      .newFrame_i       (newFrame),
      .pixelValid_i     (pixelValid),
      .pixelMask_i      (pixelMask),
      .memAddress_o     (memAddress),
      .memWriteEnable_o (memWriteEnable),
      .memDataOut_o     (memDataOut),
      .busy_o           (busy),
      .frameDone_o      (frameDone),
      .clearDone_o      (clearDone)
   );

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [13:0] addr;
      logic [31:0] data;
      logic        fd;
      logic        cd;
   } wr_t;

   wr_t   exp_q[$];
   bit    m_bits[$];
   bit    m_cap;
   int    m_clear_until;
   int    m_words;
   bit    m_busy;
   bit    m_rst_prev;
   bit    grab_word0;
   logic [31:0] word0_seen = '0;
   int    tests = 0;
   int    fails = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] packed_word();
      longint v = 0;
      foreach (m_bits[i]) v += longint'(m_bits[i]) << i;
      return 32'(v);
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_bits.delete();
      m_cap         = 1'b0;
      m_clear_until = -1;
      m_words       = 0;
      m_busy        = 1'b0;
   endtask

   task automatic push_write(input int c, input int addr, input logic [31:0] data, input bit fd, input bit cd);
      wr_t w;
      w.cyc  = c;
      w.addr = 14'(addr);
      w.data = data;
      w.fd   = fd;
      w.cd   = cd;
      exp_q.push_back(w);
   endtask

   // Model of what happens at edge e given the inputs presented before it.
   task automatic model_step(input int e, input bit nf, input bit sc, input logic [31:0] cv,
                             input bit pv, input bit pm);
      bit fin;
      fin = 1'b0;
      if (e <= m_clear_until) begin
         m_busy = 1'b1;
         return;
      end
      if (!m_cap) begin
         if (CLR_EN && sc) begin
            for (int k = 0; k < NW; k++) push_write(e + 1 + k, k, cv, 1'b0, k == NW - 1);
            m_clear_until = e + NW;
            m_busy        = 1'b1;
            return;
         end
         if (!nf) begin
            m_busy = 1'b0;
            return;
         end
         m_cap = 1'b1;
         m_bits.delete();
         m_words = 0;
      end else if (nf) begin
         m_bits.delete();
         m_words = 0;
      end
      if (pv) begin
         m_bits.push_back(pm);
         if (m_bits.size() == 32) begin
            push_write(e, m_words, packed_word(), m_words == NW - 1, 1'b0);
            m_bits.delete();
            m_words++;
            if (m_words == NW) begin
               m_cap = 1'b0;
               fin   = 1'b1;
            end
         end
      end
      m_busy = m_cap || fin;
   endtask

   task automatic check_outputs();
      wr_t w;
      logic [2:0] flags;
      flags = {memWriteEnable, frameDone, clearDone};
      if (m_rst_prev) check("reset_zero", {memAddress, memDataOut, flags, busy}, '0);
      if (grab_word0 && memWriteEnable === 1'b1 && memAddress == 14'd0) begin
         word0_seen = memDataOut;
         grab_word0 = 1'b0;
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         w = exp_q.pop_front();
         check("write_flags", flags, {1'b1, w.fd, w.cd});
         check("write_addr_data", {memAddress, memDataOut}, {w.addr, w.data});
      end else begin
         check("no_write", flags, 3'b000);
      end
      check("busy", busy, m_busy);
   endtask

   task automatic cyc_step(input bit rst, input bit nf, input bit sc, input logic [31:0] cv,
                           input bit pv, input bit pm);
      @(negedge clock);
      check_outputs();
      reset      = rst;
      newFrame   = nf;
      startClear = sc;
      clearValue = cv;
      pixelValid = pv;
      pixelMask  = pm;
      if (rst) begin
         model_reset();
         m_rst_prev = 1'b1;
      end else begin
         m_rst_prev = 1'b0;
         model_step(cyc + 1, nf, sc, cv, pv, pm);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc_step(1'b0, 1'b0, 1'b0, $urandom, 1'b0, 1'b0);
   endtask

   task automatic rand_pixels(input int n);
      for (int i = 0; i < n; i++) cyc_step(1'b0, 1'b0, 1'b0, '0, 1'b1, bit'($urandom_range(0, 1)));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; startClear = 1'b0; clearValue = '0;
      newFrame = 1'b0; pixelValid = 1'b0; pixelMask = 1'b0;
      grab_word0 = 1'b0;
      repeat (2) @(posedge clock);
      model_reset();
      m_rst_prev = 1'b1;
      idle(2);

      // full frame, mask = (pixel index mod 3 == 0), with random gaps
      grab_word0 = 1'b1;
      cyc_step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < NW * 32; ) begin
         if ($urandom_range(0, 3) == 0) begin
            cyc_step(1'b0, 1'b0, 1'b0, '0, 1'b0, bit'($urandom_range(0, 1)));
         end else begin
            cyc_step(1'b0, 1'b0, 1'b0, '0, 1'b1, (i % 3) == 0);
            i++;
         end
      end
      rand_pixels(5);
      idle(3);
      check("word0", word0_seen, 32'h4924_9249);

      // back-to-back packing: 32 ones then 32 zeros
      cyc_step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 64; i++) cyc_step(1'b0, 1'b0, 1'b0, '0, 1'b1, i < 32);
      idle(2);
      cyc_step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      idle(2);

      // restart mid-word
      cyc_step(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
      rand_pixels(40);
      cyc_step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
      rand_pixels(31);
      idle(2);
      cyc_step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      idle(2);

      // reset after 10 words, then a fresh frame starts at address 0
      cyc_step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
      rand_pixels(324);
      cyc_step(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1);
      rand_pixels(3);
      cyc_step(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
      rand_pixels(31);
      idle(2);
      cyc_step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      idle(2);

      // clear pass with newFrame and startClear pulsed mid-clear
      cyc_step(1'b0, 1'b0, 1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
      for (int i = 0; i < NW + 4; i++)
         cyc_step(1'b0, i == NW / 2, i == 10, $urandom, 1'b1, bit'($urandom_range(0, 1)));
      idle(2);
      cyc_step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      idle(2);

      // simultaneous startClear and newFrame in IDLE
      cyc_step(1'b0, 1'b1, 1'b1, $urandom, 1'b1, 1'b1);
      rand_pixels(NW + 40);
      idle(NW + 3);
      cyc_step(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      idle(2);

      // random traffic
      for (int i = 0; i < 3000; i++)
         cyc_step($urandom_range(0, 999) == 0, $urandom_range(0, 199) == 0,
                  $urandom_range(0, 299) == 0, $urandom,
                  $urandom_range(0, 3) != 0, bit'($urandom_range(0, 1)));

      idle(NW + 3);
      check("pending_writes", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
